// File: rtl/fpu_vec_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_vec_seq_if : operation request and result return channels        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface fpu_vec_seq_if #(
  parameter int WIDTH = 24,
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_ctrl;
  logic [LANES-1:0]       in_mask;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_result;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_ctrl, in_mask, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_ctrl, in_mask, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/fpu_vec_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_vec_seq : issues one lane per cycle of a vector op to the FPU    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fpu_vec_seq #(
  parameter int WIDTH = 24,
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  fpu_vec_seq_if.slave          bus,
  output logic [WIDTH-1:0]      fpu_a,
  output logic [WIDTH-1:0]      fpu_b,
  output logic [2:0]            fpu_ctrl,
  input  wire logic [WIDTH-1:0] fpu_out
);
  localparam int                 c_cnt_w    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(LANES - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
  localparam logic [2:0]         c_ctrl_nop = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_b;
  logic [LANES*WIDTH-1:0] r_result;
  logic [2:0]             r_ctrl;
  logic [LANES-1:0]       r_mask;
  logic [TAG_W-1:0]       r_tag;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last;
  logic [WIDTH-1:0]       w_a_lane [LANES];
  logic [WIDTH-1:0]       w_b_lane [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_a_lane[k] = r_a[k*WIDTH +: WIDTH];
    assign w_b_lane[k] = r_b[k*WIDTH +: WIDTH];
  end

  // A finished result can be swapped for a new op in the same cycle it is consumed
  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == c_last);

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == ST_DONE);
  assign bus.out_result = r_result;
  assign bus.out_tag    = r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The FPU is steered to its zero-output opcode whenever no lane is in flight
  always_comb begin
    fpu_a    = '0;
    fpu_b    = '0;
    fpu_ctrl = c_ctrl_nop;
    if (r_state == ST_RUN) begin
      fpu_a    = w_a_lane[r_cnt];
      fpu_b    = w_b_lane[r_cnt];
      fpu_ctrl = r_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_ctrl   <= '0;
      r_mask   <= '0;
      r_tag    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= bus.in_a;
      r_b      <= bus.in_b;
      r_ctrl   <= bus.in_ctrl;
      r_mask   <= bus.in_mask;
      r_tag    <= bus.in_tag;
      r_result <= '0;
    end else if (r_state == ST_RUN) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_cnt == c_cnt_w'(k)) begin
          r_result[k*WIDTH +: WIDTH] <= r_mask[k] ? fpu_out : '0;
        end
      end
      r_cnt <= w_last ? '0 : r_cnt + c_one;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fpu_vec_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fpu_vec_seq : directed bench with cycle-level reference model     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fpu_vec_seq;
  localparam int WIDTH = 24;
  localparam int LANES = 4;
  localparam int TAG_W = 4;
  localparam int VW    = LANES * WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_vec_seq_if #(.WIDTH(WIDTH), .LANES(LANES), .TAG_W(TAG_W)) bus ();

  logic [WIDTH-1:0] fpu_a;
  logic [WIDTH-1:0] fpu_b;
  logic [WIDTH-1:0] fpu_out;
  logic [2:0]       fpu_ctrl;

  fpu_vec_seq #(.WIDTH(WIDTH), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fpu_a    (fpu_a),
    .fpu_b    (fpu_b),
    .fpu_ctrl (fpu_ctrl),
    .fpu_out  (fpu_out)
  );

  // Stand-in FPU: exact for the operand pairs used here, an arbitrary fixed map elsewhere
  function automatic logic [WIDTH-1:0] fpu_ref(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return (a == 24'h3F8000 && b == 24'h3F8000) ? 24'h400000 : (a ^ b);
      3'b001:  return a + b;
      3'b010:  return (a == 24'h400000 && b == 24'h404000) ? 24'h40C000 : (a ^ ~b);
      3'b011:  return (a > b) ? a : b;
      3'b100:  return (a < b) ? a : b;
      3'b101:  return {1'b0, a[WIDTH-2:0]};
      3'b110:  return {~a[WIDTH-1], a[WIDTH-2:0]};
      default: return '0;
    endcase
  endfunction

  assign fpu_out = fpu_ref(fpu_ctrl, fpu_a, fpu_b);

  function automatic logic [VW-1:0] vec_ref(input logic [2:0] op, input logic [LANES-1:0] mask,
                                            input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      if (mask[k]) r[k*WIDTH +: WIDTH] = fpu_ref(op, a[k*WIDTH +: WIDTH], b[k*WIDTH +: WIDTH]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an op is busy for LANES cycles after acceptance, then presented until taken
  logic             m_busy;
  logic             m_done;
  int               m_lane;
  logic [VW-1:0]    m_a, m_b, m_res;
  logic [2:0]       m_ctrl;
  logic [TAG_W-1:0] m_tag;

  function automatic logic m_ready();
    return !m_busy && (!m_done || bus.out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_lane <= 0;
      m_a <= '0; m_b <= '0; m_res <= '0; m_ctrl <= '0; m_tag <= '0;
    end else begin
      if (m_busy) begin
        if (m_lane == LANES - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
        m_lane <= m_lane + 1;
      end else if (m_done && bus.out_ready) begin
        m_done <= 1'b0;
      end
      if (bus.in_valid && m_ready()) begin
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_lane <= 0;
        m_a    <= bus.in_a;
        m_b    <= bus.in_b;
        m_ctrl <= bus.in_ctrl;
        m_tag  <= bus.in_tag;
        m_res  <= vec_ref(bus.in_ctrl, bus.in_mask, bus.in_a, bus.in_b);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", VW'(bus.in_ready), VW'(m_ready()));
      chk("out_valid", VW'(bus.out_valid), VW'(m_done));
      if (m_done) begin
        chk("out_result", bus.out_result, m_res);
        chk("out_tag", VW'(bus.out_tag), VW'(m_tag));
      end
      if (m_busy) begin
        chk("fpu_a", VW'(fpu_a), VW'(m_a[m_lane*WIDTH +: WIDTH]));
        chk("fpu_b", VW'(fpu_b), VW'(m_b[m_lane*WIDTH +: WIDTH]));
        chk("fpu_ctrl", VW'(fpu_ctrl), VW'(m_ctrl));
      end else begin
        chk("fpu_a_idle", VW'(fpu_a), '0);
        chk("fpu_b_idle", VW'(fpu_b), '0);
        chk("fpu_ctrl_idle", VW'(fpu_ctrl), VW'(3'b111));
      end
    end
  end

  // Result-channel monitor: valid rising edges and completed handshakes
  logic             prev_valid;
  int               rise_q[$];
  int               hs_q[$];
  logic [VW-1:0]    res_q[$];
  logic [TAG_W-1:0] tag_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid <= bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        res_q.push_back(bus.out_result);
        tag_q.push_back(bus.out_tag);
        hs_q.push_back(cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic drive_op(input logic [2:0] ctrl, input logic [LANES-1:0] mask,
                          input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [TAG_W-1:0] tag, output int acc_cyc);
    bus.in_ctrl  = ctrl;
    bus.in_mask  = mask;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    acc_cyc      = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (acc_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready never seen, tag %0d", tag);
    end
  endtask

  task automatic wait_results(input int n);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (res_q.size() >= n) break;
    end
    if (i == 100) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: have %0d results, need %0d", res_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  int acc, acc2, n0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_mask   = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", VW'(bus.out_valid), '0);
    chk("rst_out_result", bus.out_result, '0);
    chk("rst_out_tag", VW'(bus.out_tag), '0);
    chk("rst_in_ready", VW'(bus.in_ready), VW'(1'b1));
    chk("rst_fpu_ctrl", VW'(fpu_ctrl), VW'(3'b111));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Negate across all lanes
    bus.out_ready = 1'b1;
    drive_op(3'b110, 4'hF, 96'h404000_BF8000_400000_3F8000, '0, 4'd5, acc);
    wait_results(1);
    chk("neg_result", res_q[0], 96'hC04000_3F8000_C00000_BF8000);
    chk("neg_tag", VW'(tag_q[0]), VW'(4'd5));
    chk_int("neg_latency", rise_q[rise_q.size()-1] - acc, LANES + 1);

    // Masked add: disabled lanes return zero
    drive_op(3'b000, 4'b0101, {4{24'h3F8000}}, {4{24'h3F8000}}, 4'd2, acc);
    wait_results(2);
    chk("add_masked_result", res_q[1], 96'h000000_400000_000000_400000);

    // Backpressure: result held while the consumer stalls
    bus.out_ready = 1'b0;
    drive_op(3'b010, 4'hF, {4{24'h400000}}, {4{24'h404000}}, 4'd7, acc);
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_result", bus.out_result, {4{24'h40C000}});
      chk("bp_in_ready", VW'(bus.in_ready), '0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_drop", VW'(bus.out_valid), '0);
    @(posedge clk);
    #1;
    chk_int("bp_result_count", res_q.size(), 3);

    // Back-to-back: second op accepted in the cycle the first is consumed
    n0 = res_q.size();
    drive_op(3'b110, 4'hF, 96'h404000_BF8000_400000_3F8000, '0, 4'd9, acc);
    drive_op(3'b111, 4'hF, {4{24'h123456}}, {4{24'h654321}}, 4'd10, acc2);
    wait_results(n0 + 2);
    chk_int("b2b_accept_gap", acc2 - acc, LANES + 1);
    chk_int("b2b_accept_on_consume", acc2, hs_q[n0]);
    chk_int("b2b_valid_spacing", rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2], LANES + 1);
    chk("b2b_tag0", VW'(tag_q[n0]), VW'(4'd9));
    chk("b2b_tag1", VW'(tag_q[n0+1]), VW'(4'd10));
    chk("b2b_nop_result", res_q[n0+1], '0);

    // All-zero mask still runs the full length
    n0 = res_q.size();
    drive_op(3'b001, 4'h0, {4{24'h3F8000}}, {4{24'h400000}}, 4'd3, acc);
    wait_results(n0 + 1);
    chk("zero_mask_result", res_q[n0], '0);
    chk_int("zero_mask_latency", rise_q[rise_q.size()-1] - acc, LANES + 1);

    // Reset with lane 2 pending: the op must vanish
    n0 = res_q.size();
    drive_op(3'b010, 4'hF, {4{24'h400000}}, {4{24'h404000}}, 4'd4, acc);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", VW'(bus.out_valid), '0);
    chk("abort_out_result", bus.out_result, '0);
    chk("abort_in_ready", VW'(bus.in_ready), VW'(1'b1));
    repeat (12) @(negedge clk);
    chk_int("abort_no_output", res_q.size(), n0);
    chk("idle_fpu_ctrl", VW'(fpu_ctrl), VW'(3'b111));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fpu_vec_seq.md
Name: fpu_vec_seq

Overview:
Vector-to-scalar sequencer directly upstream of the 24-bit scalar FPU in the shader core. It accepts one LANES-wide vector FP operation over a valid/ready handshake and latches the operands. It then issues one lane per cycle to the combinational FPU and captures each lane's result. It returns the assembled result vector over a second valid/ready handshake. The result is held stable until it is consumed.

Parameters:
WIDTH, 24, scalar FP word width (1 sign, 8 exponent, 15 mantissa); must match the FPU.
LANES, 4, lanes per vector op; must be at least 2.
TAG_W, 4, width of the opaque tag carried from input to output.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  a vector op is presented.
in_ready  out  1  the sequencer can accept an op this cycle.
in_ctrl  in  3  FPU opcode (000 add, 001 sub, 010 mul, 011 max, 100 min, 101 abs, 110 neg).
in_mask  in  LANES  lane enables; bit k enables lane k.
in_a  in  LANES*WIDTH  operand A; lane k is bits [k*WIDTH +: WIDTH].
in_b  in  LANES*WIDTH  operand B, same packing as in_a.
in_tag  in  TAG_W  tag, returned unchanged on out_tag.
fpu_a  out  WIDTH  to FPU operand a.
fpu_b  out  WIDTH  to FPU operand b.
fpu_ctrl  out  3  to FPU control.
fpu_out  in  WIDTH  combinational result from the FPU.
out_valid  out  1  result vector available.
out_ready  in  1  consumer accepts the result.
out_result  out  LANES*WIDTH  result vector, same packing as in_a.
out_tag  out  TAG_W  tag of the op being returned.

Behaviour:
- States: IDLE, RUN, DONE.
- Lane counter cnt: width clog2(LANES).
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0.
  - out_valid = 0, out_result = 0, out_tag = 0.
  - All latched operands, ctrl, mask and tag cleared.
- Reset during RUN or DONE: the op is discarded and never appears on the output.
- in_ready = (state == IDLE) OR (state == DONE AND out_ready). It is combinational and does not depend on in_valid.
- Accept: a rising edge with in_valid AND in_ready.
  - Latches in_a, in_b, in_ctrl, in_mask, in_tag.
  - Sets state = RUN, cnt = 0, and clears out_result to 0.
- RUN, each cycle:
  - fpu_a = a[cnt], fpu_b = b[cnt], fpu_ctrl = latched ctrl.
  - At the edge, result[cnt] takes fpu_out if mask[cnt] = 1, otherwise 0.
  - cnt increments at the edge.
  - At cnt == LANES-1 the state moves to DONE at that edge.
  - Fixed length: always exactly LANES cycles, whatever the mask. An all-zero mask still takes LANES cycles and yields an all-zero result.
- Outside RUN: fpu_a = 0, fpu_b = 0, fpu_ctrl = 3'b111 (FPU outputs 0).
- DONE:
  - out_valid = 1. out_result and out_tag are held stable while out_ready = 0.
  - On out_valid AND out_ready: go to RUN if a new op is accepted in the same cycle, otherwise to IDLE.
- Latency: accept in cycle T gives out_valid in cycle T+LANES+1. Back-to-back throughput is one op per LANES+1 cycles.
- Opcode 111 presented on in_ctrl: accepted as normal and yields zeros in enabled lanes.
- in_valid dropped before acceptance: no state change.
- No rounding or exception flags; the FPU result is captured verbatim.

Test Plan:
- Reset:
  - Assert rst_n = 0 mid-RUN with lane 2 pending → out_valid = 0, out_result = 0, in_ready = 1 on the cycle after release, and no output for the aborted op.
  - Check fpu_ctrl = 111 while idle.
- Negate, all lanes:
  - Stimulus: in_ctrl = 110, mask = 1111, a = {3F8000, 400000, BF8000, 404000} (lanes 0..3), tag = 5.
  - Required: out_result lanes = {BF8000, C00000, 3F8000, C04000} and out_tag = 5, with out_valid exactly 5 cycles after the accept cycle.
- Add, masked:
  - Stimulus: in_ctrl = 000, mask = 0101, a lanes all 3F8000, b lanes all 3F8000.
  - Required: lanes 0 and 2 = 400000, lanes 1 and 3 = 000000.
  - Required: fpu_a and fpu_b toggle through all 4 lanes regardless of the mask.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid rises (mul, mask = 1111, a = 400000, b = 404000).
  - Required: out_result stays at C0 4000 ×… i.e. 40C000 in every lane, stable throughout; in_ready = 0 throughout.
  - Release out_ready → out_valid drops the next cycle.
- Back-to-back:
  - Keep in_valid high with two ops and out_ready = 1.
  - Required: the second op is accepted in the same cycle the first result is consumed (in_ready = 1 in DONE); out_valid pulses are LANES+1 = 5 cycles apart and the tags are returned in order.
- All-zero mask:
  - Stimulus: mask = 0000, any opcode.
  - Required: out_valid after 5 cycles with out_result = 0.
